mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-low.
REQ-002 SHALL expose ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
- opcode  in  4  instruction opcode from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion handshake.
- ir_ld  out  1  load IR from memory data.
- pc_ld  out  1  load PC.
- pc_src  out  2  PC source: 0=PC+1, 1=branch target, 2=jump target.
- iord  out  1  memory address source: 0=PC, 1=ALU result register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- alu_src_imm  out  1  ALU operand B is the immediate.
- sel_func  out  1  ALU operation comes from the instruction function field.
- alu_op  out  8  ALU one-hot operation: ADD=0x02, SUB=0x04, AND=0x08, OR=0x10, NOP=0x40.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register select: 1 for TYPEC.
- wb_sel  out  1  write-back source: 0=ALU, 1=memory data.
- state  out  3  current FSM state, for debug.
- illegal  out  1  sticky flag for an unknown opcode.
- retired  out  16  count of completed instructions.
REQ-003 SHALL decode these opcodes: LOAD=0000, STORE=0001, JUMP=0010, BRANCHZ=0100, TYPEC=1000, ADDI=1100, SUBI=1101, ANDI=1110, ORI=1111. Every other opcode is illegal.

Function
REQ-004 SHALL implement these states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-005 SHALL hold every output listed below at 0 unless that state asserts it; alu_op defaults to NOP.
REQ-006 FETCH:
- Asserts mem_read=1 and iord=0 until mem_ready=1.
- In the cycle mem_ready=1, also asserts ir_ld=1, pc_ld=1 and pc_src=0, then moves to DECODE.
- While mem_ready=0, stays in FETCH.
REQ-007 DECODE:
- Latches opcode into an internal op_q register.
- JUMP: asserts pc_ld=1 and pc_src=2, increments retired, moves to FETCH.
- Illegal opcode: moves to HALT.
- All other opcodes: moves to EXEC.
REQ-008 EXEC drives alu_op from op_q and then transitions as follows:
- LOAD/STORE: ADD with alu_src_imm=1, then MEM.
- ADDI/SUBI/ANDI/ORI: ADD/SUB/AND/OR respectively with alu_src_imm=1, then WB.
- TYPEC: sel_func=1 and alu_op=NOP, then WB.
- BRANCHZ: SUB; if zero=1, asserts pc_ld=1 and pc_src=1. Either way, increments retired and moves to FETCH.
REQ-009 MEM:
- Asserts iord=1, plus mem_read=1 (LOAD) or mem_write=1 (STORE), held until mem_ready=1.
- On mem_ready=1: LOAD moves to WB; STORE increments retired and moves to FETCH.
REQ-010 WB:
- Asserts reg_write=1 for exactly one cycle.
- wb_sel=1 for LOAD; reg_dst=1 for TYPEC.
- Increments retired and moves to FETCH.
REQ-011 HALT SHALL set illegal=1, drive all strobes to 0, and remain in HALT until reset.
REQ-012 Latency with mem_ready held at 1:
- JUMP: 2 cycles.
- BRANCHZ: 3 cycles.
- STORE and ALU instructions: 4 cycles.
- LOAD: 5 cycles.
- Each cycle of mem_ready=0 in FETCH or MEM adds one cycle.
REQ-013 retired SHALL be a 16-bit modulo counter: 0xFFFF increments to 0x0000.
REQ-014 mem_read and mem_write SHALL never be asserted in the same cycle; reg_write and pc_ld SHALL be asserted at most once per instruction.
REQ-015 opcode SHALL be sampled only in DECODE; changes to opcode in any other state SHALL have no effect.

Reset
REQ-016 rst=0 at a rising edge SHALL set state=FETCH, op_q=0, illegal=0 and retired=0, overriding any transition, including one out of HALT or one mid-handshake.
REQ-017 While rst=0, all outputs SHALL be 0 except alu_op=NOP and state=0.
REQ-018 In the first cycle after rst returns to 1, the block SHALL assert mem_read=1 and iord=0.

Verification
REQ-019 ADDI with mem_ready=1 -> cycle 3 has alu_op=0x02 and alu_src_imm=1; cycle 4 has reg_write=1 and wb_sel=0; retired 0->1.
REQ-020 LOAD with mem_ready low for 2 cycles in MEM -> mem_read=1 and iord=1 held for 3 cycles; WB has wb_sel=1; total 7 cycles.
REQ-021 BRANCHZ with zero=1 -> EXEC has pc_ld=1, pc_src=1, alu_op=0x04; with zero=0 -> EXEC has pc_ld=0; both return to FETCH.
REQ-022 Opcode 0011 -> DECODE then HALT; illegal=1 with no strobes; rst=0 -> state=0 and illegal=0.
REQ-023 Preload retired=0xFFFF via 65535 JUMPs, then one more JUMP -> retired=0x0000.
REQ-024 rst=0 asserted in MEM during STORE -> next cycle mem_write=0 and state=FETCH; no retire counted.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with an
// illegal-opcode halt and a retired-instruction counter.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src_imm,
    output logic        sel_func,
    output logic [7:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_TYPEC   = 4'b1000;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    localparam logic [7:0] ALU_ADD = 8'h02;
    localparam logic [7:0] ALU_SUB = 8'h04;
    localparam logic [7:0] ALU_AND = 8'h08;
    localparam logic [7:0] ALU_OR  = 8'h10;
    localparam logic [7:0] ALU_NOP = 8'h40;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op_q;
    logic        r_illegal;
    logic [15:0] r_retired;

    logic        w_ir_ld;
    logic        w_pc_ld;
    logic [1:0]  w_pc_src;
    logic        w_iord;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_alu_src_imm;
    logic        w_sel_func;
    logic [7:0]  w_alu_op;
    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_wb_sel;
    logic        w_retire;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_next        = r_state;
        w_ir_ld       = 1'b0;
        w_pc_ld       = 1'b0;
        w_pc_src      = 2'd0;
        w_iord        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_alu_src_imm = 1'b0;
        w_sel_func    = 1'b0;
        w_alu_op      = ALU_NOP;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_wb_sel      = 1'b0;
        w_retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_ld = 1'b1;
                    w_pc_ld = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_JUMP: begin
                        w_pc_ld  = 1'b1;
                        w_pc_src = 2'd2;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    OP_LOAD, OP_STORE, OP_BRANCHZ, OP_TYPEC,
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: w_next = S_EXEC;
                    default: w_next = S_HALT;
                endcase
            end
            S_EXEC: begin
                case (r_op_q)
                    OP_LOAD, OP_STORE: begin
                        w_alu_op      = ALU_ADD;
                        w_alu_src_imm = 1'b1;
                        w_next        = S_MEM;
                    end
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                        w_alu_src_imm = 1'b1;
                        w_next        = S_WB;
                        case (r_op_q[1:0])
                            2'b00:   w_alu_op = ALU_ADD;
                            2'b01:   w_alu_op = ALU_SUB;
                            2'b10:   w_alu_op = ALU_AND;
                            default: w_alu_op = ALU_OR;
                        endcase
                    end
                    OP_TYPEC: begin
                        w_sel_func = 1'b1;
                        w_next     = S_WB;
                    end
                    OP_BRANCHZ: begin
                        w_alu_op = ALU_SUB;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                        if (zero) begin
                            w_pc_ld  = 1'b1;
                            w_pc_src = 2'd1;
                        end
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_mem_read  = (r_op_q == OP_LOAD);
                w_mem_write = (r_op_q != OP_LOAD);
                if (mem_ready) begin
                    if (r_op_q == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_wb_sel    = (r_op_q == OP_LOAD);
                w_reg_dst   = (r_op_q == OP_TYPEC);
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_op_q    <= 4'd0;
            r_illegal <= 1'b0;
            r_retired <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_retired <= r_retired + {15'd0, w_retire};
            if (r_state == S_DECODE)
                r_op_q <= opcode;
            if (w_next == S_HALT)
                r_illegal <= 1'b1;
        end
    end

    // Outputs are forced quiet combinationally while reset is held low.
    assign ir_ld       = rst & w_ir_ld;
    assign pc_ld       = rst & w_pc_ld;
    assign pc_src      = rst ? w_pc_src : 2'd0;
    assign iord        = rst & w_iord;
    assign mem_read    = rst & w_mem_read;
    assign mem_write   = rst & w_mem_write;
    assign alu_src_imm = rst & w_alu_src_imm;
    assign sel_func    = rst & w_sel_func;
    assign alu_op      = rst ? w_alu_op : ALU_NOP;
    assign reg_write   = rst & w_reg_write;
    assign reg_dst     = rst & w_reg_dst;
    assign wb_sel      = rst & w_wb_sel;
    assign state       = rst ? r_state : 3'd0;
    assign illegal     = rst & r_illegal;
    assign retired     = rst ? r_retired : 16'd0;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: per-cycle control-word
// comparisons against hand-computed values for each instruction class.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        ir_ld, pc_ld, iord, mem_read, mem_write, alu_src_imm, sel_func;
    logic        reg_write, reg_dst, wb_sel, illegal;
    logic [1:0]  pc_src;
    logic [7:0]  alu_op;
    logic [2:0]  state;
    logic [15:0] retired;

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src_imm(alu_src_imm),
        .sel_func(sel_func), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .state(state), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OP_LOAD = 4'b0000, OP_STORE = 4'b0001, OP_JUMP = 4'b0010;
    localparam logic [3:0] OP_BRZ = 4'b0100, OP_TYPEC = 4'b1000, OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101, OP_ANDI = 4'b1110, OP_ORI = 4'b1111;
    localparam logic [7:0] A_ADD = 8'h02, A_SUB = 8'h04, A_AND = 8'h08, A_OR = 8'h10, A_NOP = 8'h40;

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] exp_ret;

    // Packed view of every control output plus state, compared cycle by cycle.
    logic [22:0] ctl;
    assign ctl = {state, ir_ld, pc_ld, pc_src, iord, mem_read, mem_write,
                  alu_src_imm, sel_func, alu_op, reg_write, reg_dst, wb_sel};

    function automatic logic [22:0] mk(input logic [2:0] st, input logic ir, input logic pl,
                                       input logic [1:0] ps, input logic io, input logic mr,
                                       input logic mw, input logic imm, input logic sf,
                                       input logic [7:0] aop, input logic rw, input logic rd,
                                       input logic wb);
        return {st, ir, pl, ps, io, mr, mw, imm, sf, aop, rw, rd, wb};
    endfunction

    logic [22:0] c_rst, c_fw, c_fg, c_dec, c_dj, c_ldst, c_mld, c_mst;
    logic [22:0] c_wb_alu, c_wb_ld, c_wb_c, c_halt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        n_cmp++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
            n_fail++;
            $display("FAIL rd_wr_exclusive: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
        end
    end

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; opcode = OP_LOAD; zero = 1'b0;
        tick(); tick();
        n_cmp++;
        if (ctl !== c_rst) begin n_fail++; $display("FAIL reset_ctl: got %h required %h", ctl, c_rst); end
        n_cmp++;
        if ({illegal, retired} !== 17'd0) begin n_fail++; $display("FAIL reset_flags: got illegal=%b retired=%h required 0/0000", illegal, retired); end
        mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== c_fw) begin n_fail++; $display("FAIL reset_release: got %h required %h", ctl, c_fw); end
        exp_ret = 16'd0;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [5] = '{OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_TYPEC};
        logic [7:0]  aops[5] = '{A_ADD, A_SUB, A_AND, A_OR, A_NOP};
        logic [22:0] exp_q[$];
        logic        rdy_q[$];
        for (int k = 0; k < 5; k++) begin
            exp_q = {}; rdy_q = {};
            if (k == 1) begin exp_q.push_back(c_fw); rdy_q.push_back(1'b0); end
            exp_q.push_back(c_fg);  rdy_q.push_back(1'b1);
            exp_q.push_back(c_dec); rdy_q.push_back(1'b1);
            exp_q.push_back(ops[k] == OP_TYPEC ? mk(3'd2,0,0,2'd0,0,0,0,0,1,A_NOP,0,0,0)
                                               : mk(3'd2,0,0,2'd0,0,0,0,1,0,aops[k],0,0,0));
            rdy_q.push_back(1'b1);
            exp_q.push_back(ops[k] == OP_TYPEC ? c_wb_c : c_wb_alu); rdy_q.push_back(1'b1);
            opcode = ops[k];
            for (int i = 0; i < exp_q.size(); i++) begin
                mem_ready = rdy_q[i];
                // Opcode changes outside DECODE must be ignored.
                if (k == 0 && i == 2) opcode = 4'b0011;
                #1;
                n_cmp++;
                if (ctl !== exp_q[i]) begin n_fail++; $display("FAIL alu_op%0d_cyc%0d: got %h required %h", k, i, ctl, exp_q[i]); end
                tick();
            end
            exp_ret++;
            n_cmp++;
            if (retired !== exp_ret) begin n_fail++; $display("FAIL alu_op%0d_retired: got %h required %h", k, retired, exp_ret); end
        end
    endtask

    task automatic test_load_stall();
        logic [22:0] exp_q[7] = '{c_fg, c_dec, c_ldst, c_mld, c_mld, c_mld, c_wb_ld};
        logic        rdy_q[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_LOAD;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy_q[i];
            #1;
            n_cmp++;
            if (ctl !== exp_q[i]) begin n_fail++; $display("FAIL load_cyc%0d: got %h required %h", i, ctl, exp_q[i]); end
            tick();
        end
        exp_ret++;
        n_cmp++;
        if (ctl !== c_fw && ctl !== c_fg) begin n_fail++; $display("FAIL load_return: got state %0d required 0", state); end
        n_cmp++;
        if (retired !== exp_ret) begin n_fail++; $display("FAIL load_retired: got %h required %h", retired, exp_ret); end
    endtask

    task automatic test_store();
        logic [22:0] exp_q[4] = '{c_fg, c_dec, c_ldst, c_mst};
        opcode = OP_STORE;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl !== exp_q[i]) begin n_fail++; $display("FAIL store_cyc%0d: got %h required %h", i, ctl, exp_q[i]); end
            tick();
        end
        exp_ret++;
        n_cmp++;
        if ({state, retired} !== {3'd0, exp_ret}) begin n_fail++; $display("FAIL store_end: got state=%0d retired=%h required 0/%h", state, retired, exp_ret); end
    endtask

    task automatic test_branchz();
        logic [22:0] exp_q[3];
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            opcode = OP_BRZ;
            mem_ready = 1'b1;
            exp_q = '{c_fg, c_dec, mk(3'd2,0,z[0],(z[0] ? 2'd1 : 2'd0),0,0,0,0,0,A_SUB,0,0,0)};
            for (int i = 0; i < 3; i++) begin
                #1;
                n_cmp++;
                if (ctl !== exp_q[i]) begin n_fail++; $display("FAIL brz_z%0d_cyc%0d: got %h required %h", z, i, ctl, exp_q[i]); end
                tick();
            end
            exp_ret++;
            n_cmp++;
            if ({state, retired} !== {3'd0, exp_ret}) begin n_fail++; $display("FAIL brz_z%0d_end: got state=%0d retired=%h required 0/%h", z, state, retired, exp_ret); end
        end
        zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [22:0] exp_q[6] = '{c_fg, c_dj, c_fg, c_dj, c_fw, c_fg};
        logic        rdy_q[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        opcode = OP_JUMP;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy_q[i];
            #1;
            n_cmp++;
            if (ctl !== exp_q[i]) begin n_fail++; $display("FAIL b2b_cyc%0d: got %h required %h", i, ctl, exp_q[i]); end
            tick();
        end
        // The last FETCH handshake leaves a JUMP in DECODE; complete it.
        #1;
        n_cmp++;
        if (ctl !== c_dj) begin n_fail++; $display("FAIL b2b_tail: got %h required %h", ctl, c_dj); end
        tick();
        exp_ret = exp_ret + 16'd3;
        n_cmp++;
        if (retired !== exp_ret) begin n_fail++; $display("FAIL b2b_retired: got %h required %h", retired, exp_ret); end
    endtask

    task automatic test_wrap();
        mem_ready = 1'b0;
        opcode = OP_JUMP;
        force dut.r_retired = 16'hFFFF;
        tick(); tick();
        release dut.r_retired;
        #1;
        n_cmp++;
        if (retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h required ffff", retired); end
        mem_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({state, retired} !== 19'd0) begin n_fail++; $display("FAIL wrap_rollover: got state=%0d retired=%h required 0/0000", state, retired); end
        exp_ret = 16'd0;
    endtask

    task automatic test_reset_mid_store();
        opcode = OP_STORE;
        mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== c_mst) begin n_fail++; $display("FAIL rstmem_in_mem: got %h required %h", ctl, c_mst); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== c_rst) begin n_fail++; $display("FAIL rstmem_held: got %h required %h", ctl, c_rst); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== c_fw) begin n_fail++; $display("FAIL rstmem_after: got %h required %h", ctl, c_fw); end
        n_cmp++;
        if (retired !== 16'd0) begin n_fail++; $display("FAIL rstmem_retired: got %h required 0000", retired); end
        exp_ret = 16'd0;
    endtask

    task automatic test_illegal();
        opcode = 4'b0011;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== c_fg) begin n_fail++; $display("FAIL ill_fetch: got %h required %h", ctl, c_fg); end
        tick();
        n_cmp++;
        if ({ctl, illegal} !== {c_dec, 1'b0}) begin n_fail++; $display("FAIL ill_decode: got %h/%b required %h/0", ctl, illegal, c_dec); end
        tick();
        opcode = OP_JUMP;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({ctl, illegal} !== {c_halt, 1'b1}) begin n_fail++; $display("FAIL ill_halt%0d: got %h/%b required %h/1", i, ctl, illegal, c_halt); end
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, illegal, retired} !== {c_fw, 17'd0}) begin n_fail++; $display("FAIL ill_reset: got %h/%b/%h required %h/0/0000", ctl, illegal, retired, c_fw); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        c_rst    = mk(3'd0,0,0,2'd0,0,0,0,0,0,A_NOP,0,0,0);
        c_fw     = mk(3'd0,0,0,2'd0,0,1,0,0,0,A_NOP,0,0,0);
        c_fg     = mk(3'd0,1,1,2'd0,0,1,0,0,0,A_NOP,0,0,0);
        c_dec    = mk(3'd1,0,0,2'd0,0,0,0,0,0,A_NOP,0,0,0);
        c_dj     = mk(3'd1,0,1,2'd2,0,0,0,0,0,A_NOP,0,0,0);
        c_ldst   = mk(3'd2,0,0,2'd0,0,0,0,1,0,A_ADD,0,0,0);
        c_mld    = mk(3'd3,0,0,2'd0,1,1,0,0,0,A_NOP,0,0,0);
        c_mst    = mk(3'd3,0,0,2'd0,1,0,1,0,0,A_NOP,0,0,0);
        c_wb_alu = mk(3'd4,0,0,2'd0,0,0,0,0,0,A_NOP,1,0,0);
        c_wb_ld  = mk(3'd4,0,0,2'd0,0,0,0,0,0,A_NOP,1,0,1);
        c_wb_c   = mk(3'd4,0,0,2'd0,0,0,0,0,0,A_NOP,1,1,0);
        c_halt   = mk(3'd5,0,0,2'd0,0,0,0,0,0,A_NOP,0,0,0);
        exp_ret  = 16'd0;

        test_reset();
        test_alu_ops();
        test_load_stall();
        test_store();
        test_branchz();
        test_back_to_back();
        test_wrap();
        test_reset_mid_store();
        test_illegal();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
